// File: rtl/lane_gate_array.sv
//============================================================================
// Module      : lane_gate_array
// Description : WIDTH-lane registered BUF/NOT array. Lane modes are loaded
//               through a valid/ready config port. A sequential counter
//               reports how many lanes invert and how many buffer.
//               Optional macro LANE_GATE_BYPASS_EN adds a stage-1 bypass.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module lane_gate_array #(
    parameter int  WIDTH = 8,
    parameter int  PIPE  = 1,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] di,
`ifdef LANE_GATE_BYPASS_EN
    input  logic             bypass,
`endif
    output logic [WIDTH-1:0] dout,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_mask,
    output logic [CNT_W-1:0] n_not,
    output logic [CNT_W-1:0] n_buf,
    output logic             cnt_valid
);

    localparam logic [CNT_W-1:0] c_width = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_last  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_scan;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_acc;
    logic             r_ready;
    logic [CNT_W-1:0] r_n_not;
    logic [CNT_W-1:0] r_n_buf;
    logic             r_cnt_valid;
    logic [WIDTH-1:0] r_pipe [PIPE];

    logic [WIDTH-1:0] w_stage1;
    logic [CNT_W-1:0] w_acc_next;

`ifdef LANE_GATE_BYPASS_EN
    assign w_stage1 = bypass ? di : (di ^ r_mask);
`else
    assign w_stage1 = di ^ r_mask;
`endif

    // r_scan is a shifted copy of the committed mask, so its LSB is mask[idx]
    assign w_acc_next = r_acc + CNT_W'(r_scan[0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_stage1;
            for (int i = 1; i < PIPE; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mask      <= '0;
            r_scan      <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_ready     <= 1'b1;
            r_n_not     <= '0;
            r_n_buf     <= c_width;
            r_cnt_valid <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid && r_ready) begin
                        r_mask      <= cfg_mask;
                        r_scan      <= cfg_mask;
                        r_idx       <= '0;
                        r_acc       <= '0;
                        r_cnt_valid <= 1'b0;
                        r_ready     <= 1'b0;
                        r_state     <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    r_acc  <= w_acc_next;
                    r_idx  <= r_idx + c_one;
                    r_scan <= r_scan >> 1;
                    if (r_idx == c_last) begin
                        r_n_not     <= w_acc_next;
                        r_n_buf     <= c_width - w_acc_next;
                        r_cnt_valid <= 1'b1;
                        r_ready     <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dout      = r_pipe[PIPE-1];
    assign cfg_ready = r_ready;
    assign n_not     = r_n_not;
    assign n_buf     = r_n_buf;
    assign cnt_valid = r_cnt_valid;

endmodule

`default_nettype wire

// File: tb/tb_lane_gate_array.sv
//============================================================================
// Module      : tb_lane_gate_array
// Description : Self-checking bench for lane_gate_array (WIDTH=8/PIPE=2 and
//               WIDTH=1/PIPE=4 instances).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_lane_gate_array;

    localparam int W = 8;
    localparam int P = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] di = '0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_mask = '0;
    logic [W-1:0] dout;
    logic         cfg_ready;
    logic [3:0]   n_not;
    logic [3:0]   n_buf;
    logic         cnt_valid;

    logic         di1 = 1'b0;
    logic         cfg_valid1 = 1'b0;
    logic         cfg_mask1 = 1'b0;
    logic         dout1;
    logic         cfg_ready1;
    logic         n_not1;
    logic         n_buf1;
    logic         cnt_valid1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lane_gate_array #(.WIDTH(W), .PIPE(P)) u_dut (
        .clk(clk), .rst_n(rst_n), .di(di), .dout(dout),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mask(cfg_mask),
        .n_not(n_not), .n_buf(n_buf), .cnt_valid(cnt_valid)
    );

    lane_gate_array #(.WIDTH(1), .PIPE(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .di(di1), .dout(dout1),
        .cfg_valid(cfg_valid1), .cfg_ready(cfg_ready1), .cfg_mask(cfg_mask1),
        .n_not(n_not1), .n_buf(n_buf1), .cnt_valid(cnt_valid1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: mask history, countdown of a pending count, and the
    // popcount published when the countdown expires.
    logic [W-1:0] m_mask;
    logic [W-1:0] m_pipe [P];
    int           m_busy = 0;
    int           m_nnot = 0;
    bit           m_valid = 1'b1;
    bit           m_ready = 1'b1;
    bit           m_init = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mask = '0;
            for (int i = 0; i < P; i++) m_pipe[i] = '0;
            m_busy  = 0;
            m_nnot  = 0;
            m_valid = 1'b1;
            m_ready = 1'b1;
            m_init  = 1'b1;
        end else begin
            for (int i = P - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = di ^ m_mask;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_nnot  = $countones(m_mask);
                    m_valid = 1'b1;
                    m_ready = 1'b1;
                end
            end else if (cfg_valid) begin
                m_mask  = cfg_mask;
                m_busy  = W;
                m_valid = 1'b0;
                m_ready = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("model_dout", dout, m_pipe[P-1]);
            check("model_n_not", n_not, m_nnot);
            check("model_n_buf", n_buf, W - m_nnot);
            check("model_cnt_valid", cnt_valid, m_valid);
            check("model_cfg_ready", cfg_ready, m_ready);
        end
    end

    logic [W-1:0] d_at [4];
    int           lowcnt;
    int           waits;
    bit           rdy;
    bit           xfer;

    initial begin
        // Reset, then di=A5 held
        di = 8'hA5;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_dout0", dout, 8'h00);
        check("rst_n_not", n_not, 4'd0);
        check("rst_n_buf", n_buf, 4'd8);
        check("rst_cnt_valid", cnt_valid, 1'b1);
        check("rst_cfg_ready", cfg_ready, 1'b1);
        @(negedge clk);
        check("rst_dout1", dout, 8'h00);
        @(negedge clk);
        check("rst_dout2", dout, 8'hA5);

        // WIDTH=1, PIPE=4 instance
        @(posedge clk); #1;
        cfg_valid1 = 1'b1;
        cfg_mask1  = 1'b1;
        tick();
        cfg_valid1 = 1'b0;
        @(negedge clk);
        check("w1_cnt_valid_low", cnt_valid1, 1'b0);
        check("w1_ready_low", cfg_ready1, 1'b0);
        @(negedge clk);
        check("w1_cnt_valid", cnt_valid1, 1'b1);
        check("w1_n_not", n_not1, 1'b1);
        check("w1_n_buf", n_buf1, 1'b0);
        check("w1_ready", cfg_ready1, 1'b1);
        di1 = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check("w1_dout_inv1", dout1, 1'b0);
        @(posedge clk); #1;
        di1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("w1_latency", dout1, (i < 4) ? 1'b0 : 1'b1);
        end

        // Transfer E0 with di=00
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_mask  = 8'hE0;
        di        = 8'h00;
        tick();
        cfg_valid = 1'b0;
        lowcnt = 0;
        for (int i = 0; i < 4; i++) d_at[i] = 8'h55;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i < 4) d_at[i] = dout;
            if (cnt_valid) break;
            lowcnt++;
        end
        check("e0_low_cycles", lowcnt, 8);
        check("e0_dout_old", d_at[1], 8'h00);
        check("e0_dout_new", d_at[2], 8'hE0);
        check("e0_n_not", n_not, 4'd3);
        check("e0_n_buf", n_buf, 4'd5);
        check("e0_ready", cfg_ready, 1'b1);

        // FF offered during COUNT must wait for ready
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_mask  = 8'h81;
        tick();
        cfg_mask = 8'hFF;
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cfg_ready) break;
            waits++;
        end
        check("hold_wait", waits, 8);
        check("hold_n_not", n_not, 4'd2);
        check("hold_n_buf", n_buf, 4'd6);
        tick();
        cfg_valid = 1'b0;
        di = 8'h5A;
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cnt_valid) break;
            waits++;
        end
        check("ff_wait", waits, 8);
        check("ff_n_not", n_not, 4'd8);
        check("ff_n_buf", n_buf, 4'd0);
        check("ff_dout", dout, 8'hA5);

        // Reset mid-COUNT
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_mask  = 8'h0F;
        tick();
        cfg_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_dout", dout, 8'h00);
        check("abort_n_not", n_not, 4'd0);
        check("abort_n_buf", n_buf, 4'd8);
        check("abort_cnt_valid", cnt_valid, 1'b1);
        check("abort_ready", cfg_ready, 1'b1);
        repeat (2) @(negedge clk);
        check("abort_mask_zero", dout, 8'h5A);
        repeat (8) @(negedge clk);
        check("abort_no_stale", n_not, 4'd0);

        // Reset and cfg_valid together
        @(posedge clk); #1;
        rst_n     = 1'b0;
        cfg_valid = 1'b1;
        cfg_mask  = 8'hFF;
        tick();
        rst_n     = 1'b1;
        cfg_valid = 1'b0;
        @(negedge clk);
        check("rstcfg_ready", cfg_ready, 1'b1);
        check("rstcfg_cnt_valid", cnt_valid, 1'b1);
        repeat (2) @(negedge clk);
        check("rstcfg_mask_zero", dout, 8'h5A);

        // Randomised traffic with a holding sender and rare resets
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rdy = cfg_ready;
            @(posedge clk); #1;
            xfer = cfg_valid && rdy && rst_n;
            if (xfer) cfg_valid = 1'b0;
            if (!cfg_valid && ($urandom % 3 == 0)) begin
                cfg_valid = 1'b1;
                case ($urandom % 4)
                    0: cfg_mask = 8'hFF;
                    1: cfg_mask = 8'h00;
                    default: cfg_mask = W'($urandom);
                endcase
            end
            rst_n = ($urandom % 150) != 0;
            di    = W'($urandom);
        end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        cfg_valid = 1'b0;
        repeat (12) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
